char_stream_source: RTL and testbench
=====================================

# char_stream_source

Buffered character transmitter that drives the character-stream input of the pattern-matching blocks. A writer loads up to DEPTH 8-bit characters. After a start command, the block replays the buffered characters in load order, one per accepted handshake, and stops cleanly with a one-cycle done pulse. The buffer is retained after a run, so the same text can be replayed against different matchers.

## Interface
- DEPTH, 16, buffer capacity in characters; power of two, at least 2
- ADDR_W, 4, log2(DEPTH)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- clear  in  1  empties the buffer (count to 0); honoured in IDLE only
- loadEn  in  1  writes loadChar into the buffer; honoured in IDLE and only when full=0
- loadChar  in  8  character to write
- start  in  1  begins a transmit run; honoured in IDLE only
- rdy  in  1  downstream ready; a character transfers on a cycle where valid=1 and rdy=1
- nextChar  out  8  character offered downstream; registered
- valid  out  1  nextChar holds a buffered character; registered
- busy  out  1  high in SEND and FINISH
- done  out  1  one-cycle pulse after the last character transfers
- full  out  1  count == DEPTH
- count  out  ADDR_W+1  number of characters loaded, 0..DEPTH

## Operation
- Reset values:
  - Outputs: nextChar=8'h00, valid=0, busy=0, done=0, full=0, count=0.
  - Internal: state=IDLE, write pointer=0, read pointer=0.
  - Buffer RAM contents are not reset; they are unreadable until rewritten.
- States: IDLE, SEND, FINISH.
- IDLE
  - clear=1: count goes to 0. If loadEn is also high, clear wins and the write is dropped.
  - loadEn=1, full=0: the buffer at index count takes loadChar, and count increments.
  - loadEn=1, full=1: the write is dropped; count stays at DEPTH and no wrap occurs.
  - start=1, count>0: go to SEND, read pointer goes to 0, and valid=1 with nextChar=buffer[0] on the next cycle.
  - start=1, count==0: go directly to FINISH, giving an empty run with no valid cycles.
  - start and loadEn in the same cycle: the load completes and the run includes the new character.
  - start and clear in the same cycle: clear wins, and the run is an empty run.
- SEND
  - valid=1 throughout, and nextChar = buffer[read pointer].
  - valid=1 and rdy=1 is a transfer. The read pointer increments and nextChar presents the following character on the next cycle.
  - Transfer with read pointer == count-1: go to FINISH, with valid=0 and nextChar=8'h00 on the next cycle.
  - rdy=0: nextChar and valid hold unchanged, with no limit on stall length.
  - loadEn, clear and start are ignored; buffer and count are unchanged.
- FINISH
  - Lasts exactly one cycle with done=1, busy=1, valid=0, then returns to IDLE.
  - Inputs are ignored in FINISH.
- Outside SEND, valid=0 and nextChar=8'h00.
- Width rules:
  - count is ADDR_W+1 bits, so DEPTH itself is representable.
  - The read and write pointers are ADDR_W bits and never wrap during a run.
- reset mid-run, in any state, forces the reset values on the next edge and abandons the run. No done pulse is issued.

## Timing
- Load: a write sampled at edge N is visible in count and full after edge N.
- Start to first character:
  - start sampled at edge N puts valid=1 after edge N.
  - So the first character is offered 1 cycle after start.
- Throughput: 1 character per cycle while rdy stays high; no bubbles between characters.
- End of run: last transfer at edge M gives done=1 after edge M, then done=0 and busy=0 after edge M+1.
- Empty run: start at edge N gives done=1 after edge N, then IDLE after edge N+1.
- Minimum run length for L characters with rdy held high: L+1 cycles from start to done deasserting.
- The next start is accepted at the first IDLE cycle following FINISH.

## Test plan
- Load and replay:
  - Stimulus: load "t","e","s","t" (count=4), then start with rdy=1.
  - Response: valid on 4 consecutive cycles with nextChar 0x74, 0x65, 0x73, 0x74.
  - Then done=1 for exactly one cycle, busy falls the cycle after, and count stays 4.
- Backpressure:
  - Stimulus: same load; during the run, rdy=0 for 3 cycles while "e" is offered.
  - Response: nextChar=0x65 and valid=1 hold for those 3 cycles.
  - No character is duplicated or dropped; the output order is unchanged.
- Full boundary:
  - Stimulus: issue 17 loads with DEPTH=16.
  - Response: full=1 after the 16th load; the 17th write is dropped and count=16.
  - A replay emits exactly the 16 loaded characters.
- Empty and clear:
  - Stimulus: clear, then start.
  - Response: valid is never asserted, done=1 the cycle after start, and the block returns to IDLE.
  - Stimulus: loadEn and clear in the same cycle.
  - Response: count=0.
- Ignored inputs in SEND:
  - Stimulus: pulse loadEn, clear and start mid-run.
  - Response: count, buffer and output sequence are unaffected.
  - Stimulus: replay once more.
  - Response: the same sequence is emitted again.
- Reset mid-run:
  - Stimulus: assert reset for one cycle while the 2nd character is offered.
  - Response: next cycle valid=0, busy=0, done=0, count=0, nextChar=0x00, with no done pulse.
  - A subsequent load and start works normally.

Source files
------------

// File: rtl/char_stream_if.sv
// Character-stream handshake between a buffered source and its consumer.
// The slave modport is the char_stream_source side.
interface char_stream_if #(
    parameter int ADDR_W = 4
);
    logic              clear;
    logic              loadEn;
    logic [7:0]        loadChar;
    logic              start;
    logic              rdy;
    logic [7:0]        nextChar;
    logic              valid;
    logic              busy;
    logic              done;
    logic              full;
    logic [ADDR_W:0]   count;

    modport slave (
        input  clear, loadEn, loadChar, start, rdy,
        output nextChar, valid, busy, done, full, count
    );

    modport master (
        output clear, loadEn, loadChar, start, rdy,
        input  nextChar, valid, busy, done, full, count
    );
endinterface

// File: rtl/char_stream_source.sv
// Buffered character transmitter: load up to DEPTH characters, then replay
// them in load order over a valid/rdy handshake, ending with a done pulse.
module char_stream_source #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    char_stream_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   count;
    logic [7:0]        next_char;
    logic              valid, busy, done;
    logic              full;
    logic              wr_en;

    assign full  = (count == FULL_CNT);
    // count doubles as the write pointer; clear takes priority over a load
    assign wr_en = !reset && (state == IDLE) && bus.loadEn && !bus.clear && !full;

    // Buffer storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[count[ADDR_W-1:0]] <= bus.loadChar;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rptr      <= '0;
            count     <= '0;
            next_char <= 8'h00;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    next_char <= 8'h00;
                    valid     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (bus.clear)
                        count <= '0;
                    else if (wr_en)
                        count <= count + ONE;
                    if (bus.start) begin
                        busy <= 1'b1;
                        rptr <= '0;
                        if (!bus.clear && (count != '0 || wr_en)) begin
                            // A load in the start cycle may itself be character 0
                            state     <= SEND;
                            valid     <= 1'b1;
                            next_char <= (count == '0) ? bus.loadChar : mem[0];
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (bus.rdy) begin
                        if ({1'b0, rptr} == count - ONE) begin
                            state     <= FINISH;
                            valid     <= 1'b0;
                            next_char <= 8'h00;
                            done      <= 1'b1;
                        end else begin
                            rptr      <= rptr + 1'b1;
                            next_char <= mem[rptr + 1'b1];
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.nextChar = next_char;
    assign bus.valid    = valid;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.full     = full;
    assign bus.count    = count;
endmodule

// File: tb/tb_char_stream_source.sv
// Bench for char_stream_source: directed scenarios plus random text and
// random backpressure, checked against a queue model of the buffer.
module tb_char_stream_source;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] mq[$];

    always #5 clk = ~clk;

    char_stream_if #(.ADDR_W(ADDR_W)) bus ();

    char_stream_source #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int n);
        chk({tag, "_valid"}, bus.valid, 0);
        chk({tag, "_next"}, bus.nextChar, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_count"}, bus.count, n);
        chk({tag, "_full"}, bus.full, (n == DEPTH));
    endtask

    task automatic load(input logic [7:0] c);
        bus.loadEn = 1'b1;
        bus.loadChar = c;
        tick();
        bus.loadEn = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(c);
        chk("load_count", bus.count, mq.size());
        chk("load_full", bus.full, (mq.size() == DEPTH));
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        mq.delete();
        chk("clear_count", bus.count, 0);
    endtask

    // Start a run and follow it to completion against the queue model.
    task automatic run(input int stall_at, input bit rnd_rdy, input bit poke,
                       input bit ld, input logic [7:0] ldc);
        int idx = 0;
        int stalls = 0;
        int guard = 0;
        int n;
        bit r;
        bit poked = 0;
        if (ld && mq.size() < DEPTH) mq.push_back(ldc);
        n = mq.size();
        bus.start = 1'b1;
        bus.loadEn = ld;
        bus.loadChar = ldc;
        bus.rdy = 1'b0;
        tick();
        bus.start = 1'b0;
        bus.loadEn = 1'b0;
        chk("run_count", bus.count, n);
        while (idx < n && guard < 2000) begin
            chk("run_valid", bus.valid, 1);
            chk("run_char", bus.nextChar, mq[idx]);
            chk("run_busy", bus.busy, 1);
            chk("run_done", bus.done, 0);
            r = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == stall_at && stalls < 3) begin
                r = 1'b0;
                stalls++;
            end
            if (poke && idx == 1 && !poked) begin
                bus.loadEn = 1'b1;
                bus.clear = 1'b1;
                bus.start = 1'b1;
                bus.loadChar = 8'hAA;
                poked = 1;
            end
            bus.rdy = r;
            tick();
            bus.loadEn = 1'b0;
            bus.clear = 1'b0;
            bus.start = 1'b0;
            if (r) idx++;
            guard++;
        end
        if (idx < n) chk("run_timeout", idx, n);
        chk("end_valid", bus.valid, 0);
        chk("end_next", bus.nextChar, 0);
        chk("end_done", bus.done, 1);
        chk("end_busy", bus.busy, 1);
        bus.rdy = 1'b0;
        tick();
        chk_idle("after", n);
    endtask

    initial begin
        reset = 1'b1;
        bus.clear = 1'b0;
        bus.loadEn = 1'b0;
        bus.loadChar = 8'h00;
        bus.start = 1'b0;
        bus.rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("reset", 0);

        // Load "test" and replay with rdy high
        load(8'h74); load(8'h65); load(8'h73); load(8'h74);
        run(-1, 0, 0, 0, 8'h00);

        // Three stall cycles while 'e' is offered
        run(1, 0, 0, 0, 8'h00);

        // Ignored loadEn/clear/start mid-run, then identical replay
        run(-1, 0, 1, 0, 8'h00);
        run(-1, 0, 0, 0, 8'h00);

        // Full boundary: 17 loads, the last is dropped
        do_clear();
        for (int i = 0; i < 17; i++) load(8'($urandom));
        chk("full_after17", bus.full, 1);
        chk("count_after17", bus.count, DEPTH);
        run(-1, 1, 0, 0, 8'h00);

        // Empty run after clear
        do_clear();
        run(-1, 0, 0, 0, 8'h00);

        // loadEn and clear together: clear wins
        load(8'h41);
        bus.loadEn = 1'b1;
        bus.clear = 1'b1;
        bus.loadChar = 8'h42;
        tick();
        bus.loadEn = 1'b0;
        bus.clear = 1'b0;
        mq.delete();
        chk("clear_wins_count", bus.count, 0);

        // start and clear together: empty run
        load(8'h43);
        bus.start = 1'b1;
        bus.clear = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.clear = 1'b0;
        mq.delete();
        chk("sc_done", bus.done, 1);
        chk("sc_valid", bus.valid, 0);
        chk("sc_count", bus.count, 0);
        tick();
        chk_idle("sc_after", 0);

        // start with loadEn: new char joins the run (also from empty)
        run(-1, 0, 0, 1, 8'h5A);
        load(8'h11); load(8'h22);
        run(-1, 1, 0, 1, 8'h33);

        // Reset while the 2nd character is offered
        bus.start = 1'b1;
        bus.rdy = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("rst_c0", bus.nextChar, mq[0]);
        tick();
        chk("rst_c1", bus.nextChar, mq[1]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rdy = 1'b0;
        mq.delete();
        chk_idle("rst", 0);
        tick();
        chk_idle("rst_nodone", 0);
        load(8'h61); load(8'h62);
        run(-1, 1, 0, 0, 8'h00);

        // Random text with random backpressure
        for (int k = 0; k < 6; k++) begin
            int len;
            do_clear();
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) load(8'($urandom));
            run(-1, 1, 0, 0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
